mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port among the instruction and data requesters of N_CORES cores.
- Each core has two requesters: I (instruction fetch) and D (data, driven by the dREN/dWEN strobes decoded in each core).
- Tracks one LL/SC reservation per core. Decides SC success, and invalidates reservations on any granted write to the reserved address.
- Sits between the cores' cache/fetch logic and the RAM model.

Parameters:
N_CORES, 2, number of cores; requester count NR = 2*N_CORES, index r = 2*core + (0=I, 1=D)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
req_ren  in  NR  read request per requester
req_wen  in  NR  write request per requester (only D requesters may assert it; I-side bits are ignored)
req_addr  in  NR*ADDR_W  address per requester
req_store  in  NR*DATA_W  write data per requester
d_ll  in  N_CORES  D request of the core is LL (valid with req_ren)
d_sc  in  N_CORES  D request of the core is SC (valid with req_wen)
req_ack  out  NR  one-cycle completion pulse to the granted requester
req_err  out  1  pulses with req_ack when the RAM reported ERROR
rdata  out  DATA_W  load data, or SC result (1 = success, 0 = fail); valid only while req_ack is high
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset: state IDLE; all outputs 0; link valid bits cleared; rr_ptr = 0 (core 0 has first priority). Reset mid-transaction aborts it; no ack is issued.
- Request rule: requester r is active when req_ren[r] | req_wen[r]. If both are set, the request is treated as a write.
- Requester handshake: hold the request stable until req_ack; change or drop it in the cycle after req_ack.
- Arbitration, in IDLE only:
  - Cores are scanned round-robin starting at rr_ptr.
  - Within a core, D wins over I.
  - The grant index, addr, store data and op are latched into registers at the clock edge.
  - rr_ptr becomes (granted core + 1) mod N_CORES.
  - No active requesters: stay in IDLE.
- FSM:
  - IDLE -> ACCESS on a grant.
  - IDLE -> SCFAIL on a grant of an SC whose reservation check fails.
  - ACCESS: ramREN or ramWEN and ramaddr/ramstore are driven from the latched registers.
    - ramstate FREE or BUSY: hold.
    - ramstate ACCESS: req_ack[g] = 1; rdata = ramload for reads, 1 for SC; -> IDLE.
    - ramstate ERROR: req_ack[g] = 1, req_err = 1, rdata = 0; -> IDLE; link state is unchanged.
  - SCFAIL: no RAM enable; req_ack[g] = 1, rdata = 0; -> IDLE.
- Latency: minimum 2 cycles from request to req_ack (grant edge plus one ACCESS cycle with ramstate = ACCESS). Back-to-back grants are separated by at least one IDLE cycle.
- RAM enables are 0 in IDLE and SCFAIL. req_ack and req_err are combinational from state and ramstate.
- LL/SC (one link {valid, addr} per core):
  - LL read completes with ACCESS: link[core] <= {1, addr}.
  - SC check at grant: link[core].valid && link[core].addr == req addr. Pass -> ACCESS (write); fail -> SCFAIL.
  - SC completes (success or fail): link[core].valid <= 0.
  - Any write completing with ACCESS (plain SW or successful SC, any core): clear every link whose addr matches.
  - An LL set and a matching invalidation never occur in the same cycle, because only one transaction completes per cycle.
- Address compare uses full ADDR_W. Word alignment is the requester's responsibility.

Decomposition:
- Shared in cpu_types_pkg: ramstate_t (FREE/BUSY/ACCESS/ERROR), arb_state_t (IDLE/ACCESS/SCFAIL), word_t.
- One sub-module: rr_picker. It is combinational: takes the active vector and rr_ptr, and returns grant index and valid, applying D-before-I within a core.
- The FSM, latch registers and link table live in mem_arbiter.

Test Plan:
1. Only core0 I reads 0x100; RAM answers ACCESS on the 3rd ACCESS cycle with 0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 3 cycles; req_ack[0] pulses with rdata=0xDEADBEEF; ramREN=0 in the next cycle.
2. Core0 I and D both request at reset release -> D (r=1) is served first, then I (r=0); rr_ptr=1 after the first grant.
3. Core0 D and core1 D request continuously -> grants alternate r1, r3, r1, r3; no requester is granted twice in a row.
4. Core0 LL 0x200 (ramload 5), then core0 SC 0x200 store 7 -> ramWEN=1, ramstore=7, rdata=1; core0 link cleared.
5. Core0 LL 0x200; core1 SW 0x200 completes; core0 SC 0x200 -> state SCFAIL, no ramWEN, req_ack[1] with rdata=0.
6. ramstate=ERROR during a core1 I read -> req_ack[2]=1, req_err=1, rdata=0; RST asserted mid-ACCESS -> all outputs 0 immediately, no ack.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Types shared between the memory arbiter and its neighbours: RAM handshake
// states, arbiter FSM states and the machine word.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_SCFAIL = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester picker: scans cores from rr_ptr upward, wrapping,
// and within a core prefers the D requester (odd index) over I (even index).
module rr_picker #(
  parameter int N_CORES = 2,
  parameter int PW      = 1,
  parameter int GW      = 2
) (
  input  logic [2*N_CORES-1:0] active,
  input  logic [PW-1:0]        rr_ptr,
  output logic [GW-1:0]        grant,
  output logic                 valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    // First pass covers rr_ptr..N_CORES-1, second pass wraps to 0..rr_ptr-1.
    for (int j = 0; j < N_CORES; j++) begin
      if (!valid && j >= int'(rr_ptr) && (active[2*j+1] || active[2*j])) begin
        valid = 1'b1;
        grant = active[2*j+1] ? GW'(2*j+1) : GW'(2*j);
      end
    end
    for (int j = 0; j < N_CORES; j++) begin
      if (!valid && j < int'(rr_ptr) && (active[2*j+1] || active[2*j])) begin
        valid = 1'b1;
        grant = active[2*j+1] ? GW'(2*j+1) : GW'(2*j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among the I and D requesters of N_CORES cores and
// keeps one LL/SC reservation per core.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [2*N_CORES-1:0]      req_ren,
  input  logic [2*N_CORES-1:0]      req_wen,
  input  logic [2*N_CORES*ADDR_W-1:0] req_addr,
  input  logic [2*N_CORES*DATA_W-1:0] req_store,
  input  logic [N_CORES-1:0]        d_ll,
  input  logic [N_CORES-1:0]        d_sc,
  output logic [2*N_CORES-1:0]      req_ack,
  output logic                      req_err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [ADDR_W-1:0]         ramaddr,
  output logic [DATA_W-1:0]         ramstore,
  input  logic [DATA_W-1:0]         ramload,
  input  logic [1:0]                ramstate
);

  localparam int NR = 2 * N_CORES;
  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int GW = $clog2(NR);
  localparam logic [NR-1:0] D_MASK = {N_CORES{2'b10}};

  arb_state_t          state;
  logic [GW-1:0]       g_idx;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_store;
  logic                lat_wr, lat_ll, lat_sc;
  logic [PW-1:0]       rr_ptr;
  logic [N_CORES-1:0]  link_valid;
  logic [ADDR_W-1:0]   link_addr [N_CORES];

  logic [NR-1:0]       active;
  logic [GW-1:0]       pick_idx;
  logic                pick_valid;
  logic [PW-1:0]       pick_core, g_core;
  logic [ADDR_W-1:0]   pick_addr;
  logic                pick_wr, pick_ll, pick_sc, sc_ok;
  ramstate_t           rs;

  // I-side write strobes are ignored; a D request with both strobes is a write.
  assign active = req_ren | (req_wen & D_MASK);

  rr_picker #(.N_CORES(N_CORES), .PW(PW), .GW(GW)) u_picker (
    .active (active),
    .rr_ptr (rr_ptr),
    .grant  (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_core = PW'(pick_idx >> 1);
  assign g_core    = PW'(g_idx >> 1);
  assign pick_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign pick_wr   = pick_idx[0] & req_wen[pick_idx];
  assign pick_ll   = pick_idx[0] & ~pick_wr & d_ll[pick_core];
  assign pick_sc   = pick_idx[0] & pick_wr & d_sc[pick_core];
  assign sc_ok     = link_valid[pick_core] && (link_addr[pick_core] == pick_addr);
  assign rs        = ramstate_t'(ramstate);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ARB_IDLE;
      g_idx      <= '0;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_wr     <= 1'b0;
      lat_ll     <= 1'b0;
      lat_sc     <= 1'b0;
      rr_ptr     <= '0;
      link_valid <= '0;
      for (int c = 0; c < N_CORES; c++) link_addr[c] <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            g_idx     <= pick_idx;
            lat_addr  <= pick_addr;
            lat_store <= req_store[pick_idx*DATA_W +: DATA_W];
            lat_wr    <= pick_wr;
            lat_ll    <= pick_ll;
            lat_sc    <= pick_sc;
            rr_ptr    <= (int'(pick_core) == N_CORES - 1) ? '0 : pick_core + 1'b1;
            state     <= (pick_sc && !sc_ok) ? ARB_SCFAIL : ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (rs == RAM_ACCESS) begin
            state <= ARB_IDLE;
            if (lat_ll) begin
              link_valid[g_core] <= 1'b1;
              link_addr[g_core]  <= lat_addr;
            end
            // A completed write kills every reservation on that address, own SC included.
            if (lat_wr) begin
              for (int c = 0; c < N_CORES; c++)
                if (link_addr[c] == lat_addr) link_valid[c] <= 1'b0;
            end
            if (lat_sc) link_valid[g_core] <= 1'b0;
          end else if (rs == RAM_ERROR) begin
            state <= ARB_IDLE;
          end
        end
        ARB_SCFAIL: begin
          link_valid[g_core] <= 1'b0;
          state              <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  logic in_acc, done_ok, done_err, done_any;

  assign in_acc   = (state == ARB_ACCESS);
  assign done_ok  = in_acc && (rs == RAM_ACCESS);
  assign done_err = in_acc && (rs == RAM_ERROR);
  assign done_any = done_ok || done_err || (state == ARB_SCFAIL);

  assign ramREN   = in_acc & ~lat_wr;
  assign ramWEN   = in_acc & lat_wr;
  assign ramaddr  = in_acc ? lat_addr : '0;
  assign ramstore = (in_acc && lat_wr) ? lat_store : '0;
  assign req_err  = done_err;

  always_comb begin
    req_ack = '0;
    if (done_any) req_ack[g_idx] = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (done_ok && !lat_wr)     rdata = ramload;
    else if (done_ok && lat_sc) rdata = DATA_W'(1);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM handshake, arbitration order and LL/SC.
module tb_mem_arbiter;

  localparam int N_CORES = 2;
  localparam int NR      = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NR-1:0]    req_ren, req_wen;
  logic [NR*32-1:0] req_addr, req_store;
  logic [1:0]       d_ll, d_sc;
  logic [NR-1:0]    req_ack;
  logic             req_err;
  logic [31:0]      rdata;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int n_checks = 0;
  int n_pass   = 0;

  logic [NR-1:0] o_ack;
  logic          o_err, o_ren, o_wen;
  logic [31:0]   o_rdata, o_addr, o_store;

  mem_arbiter #(.N_CORES(N_CORES), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .d_ll(d_ll), .d_sc(d_sc),
    .req_ack(req_ack), .req_err(req_err), .rdata(rdata),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // Presents one request from an idle arbiter, lets the RAM stay BUSY for
  // 'busy' cycles, then answers rs_fin and captures the outputs of that cycle.
  task automatic txn(input int r, input bit wr, input logic [31:0] addr, input logic [31:0] store,
                     input bit ll, input bit sc, input int busy,
                     input logic [1:0] rs_fin, input logic [31:0] load);
    req_ren[r] = !wr;
    req_wen[r] = wr;
    req_addr[r*32 +: 32]  = addr;
    req_store[r*32 +: 32] = store;
    d_ll[r/2] = ll;
    d_sc[r/2] = sc;
    step();
    repeat (busy) begin
      ramstate = 2'd1;
      step();
    end
    ramstate = rs_fin;
    ramload  = load;
    @(negedge CLK);
    o_ack = req_ack; o_err = req_err; o_rdata = rdata;
    o_ren = ramREN;  o_wen = ramWEN;  o_addr = ramaddr; o_store = ramstore;
    step();
    req_ren[r] = 1'b0;
    req_wen[r] = 1'b0;
    d_ll[r/2]  = 1'b0;
    d_sc[r/2]  = 1'b0;
    ramstate   = 2'd0;
    ramload    = '0;
  endtask

  logic [NR-1:0] alt_exp [8];

  initial begin
    RST = 1'b1;
    req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
    d_ll = '0; d_sc = '0; ramload = '0; ramstate = 2'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ack", req_ack, 0);
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_rdata", rdata, 0);
    RST = 1'b0;

    // 1: single I read, RAM answers on the third ACCESS cycle
    req_ren[0] = 1'b1;
    req_addr[31:0] = 32'h100;
    step();
    ramstate = 2'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("t1_ren_busy", ramREN, 1);
      chk("t1_addr_busy", ramaddr, 32'h100);
      chk("t1_ack_busy", req_ack, 0);
      step();
    end
    ramstate = 2'd2;
    ramload  = 32'hDEADBEEF;
    @(negedge CLK);
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    step();
    req_ren[0] = 1'b0;
    ramstate = 2'd0;
    @(negedge CLK);
    chk("t1_ren_after", ramREN, 0);
    chk("t1_ack_after", req_ack, 0);
    step();

    // 2: core0 I and D together, D first
    pulse_reset();
    req_ren[1:0] = 2'b11;
    req_addr[31:0]  = 32'h10;
    req_addr[63:32] = 32'h20;
    ramstate = 2'd2;
    ramload  = 32'h55;
    @(negedge CLK);
    chk("t2_idle_ack", req_ack, 0);
    step();
    @(negedge CLK);
    chk("t2_ack_d", req_ack, 4'b0010);
    chk("t2_addr_d", ramaddr, 32'h20);
    chk("t2_rr_ptr", dut.rr_ptr, 1);
    step();
    req_ren[1] = 1'b0;
    @(negedge CLK);
    chk("t2_gap_ack", req_ack, 0);
    step();
    @(negedge CLK);
    chk("t2_ack_i", req_ack, 4'b0001);
    chk("t2_addr_i", ramaddr, 32'h10);
    step();
    req_ren[0] = 1'b0;
    ramstate = 2'd0;

    // 3: both D requesters held continuously alternate
    pulse_reset();
    req_ren[1] = 1'b1;
    req_ren[3] = 1'b1;
    req_addr[63:32]  = 32'h30;
    req_addr[127:96] = 32'h40;
    ramstate = 2'd2;
    alt_exp = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk($sformatf("t3_alt%0d", i), req_ack, alt_exp[i]);
      step();
    end
    req_ren = '0;
    ramstate = 2'd0;
    step();

    // 4: LL then matching SC succeeds
    txn(1, 0, 32'h200, 0, 1, 0, 0, 2'd2, 32'd5);
    chk("t4_ll_ack", o_ack, 4'b0010);
    chk("t4_ll_rdata", o_rdata, 5);
    chk("t4_link_set", dut.link_valid[0], 1);
    txn(1, 1, 32'h200, 32'd7, 0, 1, 0, 2'd2, 32'hBAD);
    chk("t4_sc_wen", o_wen, 1);
    chk("t4_sc_store", o_store, 7);
    chk("t4_sc_rdata", o_rdata, 1);
    chk("t4_sc_ack", o_ack, 4'b0010);
    chk("t4_link_clr", dut.link_valid[0], 0);

    // 5: other core's store to the reserved address breaks the SC
    txn(1, 0, 32'h200, 0, 1, 0, 0, 2'd2, 32'd5);
    txn(3, 1, 32'h200, 32'd9, 0, 0, 1, 2'd2, 32'hBAD);
    chk("t5_sw_ack", o_ack, 4'b1000);
    chk("t5_sw_wen", o_wen, 1);
    chk("t5_sw_rdata", o_rdata, 0);
    chk("t5_link_inval", dut.link_valid[0], 0);
    txn(1, 1, 32'h200, 32'd7, 0, 1, 0, 2'd2, 32'hBAD);
    chk("t5_scf_wen", o_wen, 0);
    chk("t5_scf_ren", o_ren, 0);
    chk("t5_scf_ack", o_ack, 4'b0010);
    chk("t5_scf_rdata", o_rdata, 0);

    // store to a different address leaves the reservation intact
    txn(3, 0, 32'h300, 0, 1, 0, 0, 2'd2, 32'd1);
    txn(1, 1, 32'h304, 32'd2, 0, 0, 0, 2'd2, 32'd0);
    chk("t5_link_kept", dut.link_valid[1], 1);
    txn(3, 1, 32'h300, 32'hA, 0, 1, 0, 2'd2, 32'hBAD);
    chk("t5_sc2_rdata", o_rdata, 1);
    chk("t5_sc2_addr", o_addr, 32'h300);

    // write strobe on an I requester is not a request
    txn(0, 1, 32'h700, 32'h1, 0, 0, 0, 2'd2, 32'd0);
    chk("t5_iwen_ack", o_ack, 0);
    chk("t5_iwen_wen", o_wen, 0);

    // 6: RAM error, then reset in the middle of an access
    txn(2, 0, 32'h400, 0, 0, 0, 1, 2'd3, 32'h1234);
    chk("t6_err_ack", o_ack, 4'b0100);
    chk("t6_err_flag", o_err, 1);
    chk("t6_err_rdata", o_rdata, 0);
    req_ren[0] = 1'b1;
    req_addr[31:0] = 32'h600;
    step();
    ramstate = 2'd2;
    ramload  = 32'hFFFF;
    #1;
    chk("t6_pre_ren", ramREN, 1);
    RST = 1'b1;
    #1;
    chk("t6_rst_ack", req_ack, 0);
    chk("t6_rst_ren", ramREN, 0);
    chk("t6_rst_addr", ramaddr, 0);
    chk("t6_rst_rdata", rdata, 0);
    req_ren[0] = 1'b0;
    step();
    RST = 1'b0;
    step();
    chk("t6_post_ack", req_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
